imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-generation stage for the ID→EX path of the pipelined MIPS core.
- Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero, sign, upper/LUI, branch-offset.
- Registers the result with a valid/ready handshake and a 2-entry skid buffer, so EX back-pressure never drops or duplicates an immediate.
- Supports a synchronous flush for branch/exception squash.

Parameters:
- IN_W, 16, immediate input width; legal range 1..OUT_W.
- OUT_W, 32, extended output width.
- SHAMT, 2, left shift applied in BRANCH mode; legal range 0..OUT_W-1.
- TAG_W, 32, width of the sideband tag (PC or instruction ID) carried alongside the immediate.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream entry offered.
- in_ready  out  1  stage can accept this cycle.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  00 ZERO, 01 SIGN, 10 UPPER, 11 BRANCH.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head.
- out_imm  out  OUT_W  extended immediate.
- out_tag  out  TAG_W  tag of the head entry.
- out_neg  out  1  MSB of out_imm, registered with the entry.

Behaviour:
Extension is combinational on input; the result is stored, not recomputed at the output.
- ZERO: {(OUT_W-IN_W) zeros, in_imm}.
- SIGN: {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
- UPPER: in_imm << (OUT_W-IN_W), low bits zero; e.g. 16→32 gives {imm, 16'h0}.
- BRANCH: SIGN result << SHAMT, truncated to OUT_W; bits shifted out are discarded, with no flag.
- When IN_W == OUT_W, all of ZERO, SIGN and UPPER equal in_imm.

Handshake:
- Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
- Latency is 1 cycle: an entry accepted at edge N is presented at out_* after edge N.
- in_ready is registered: it is 1 unless the buffer holds 2 entries. It is never combinationally derived from out_ready.
- out_* hold stable while out_valid && !out_ready.

Buffer FSM, states EMPTY / ONE / FULL (entry count):
- EMPTY: in fire → ONE.
- ONE: in fire only → FULL. Out fire only → EMPTY. Both fire → ONE, head replaced by the new entry.
- FULL: in_ready=0. Out fire → ONE, second entry promoted to head.
- Order is strict FIFO; an entry is never reordered, dropped or duplicated.

Flush:
- At the edge where flush=1, state → EMPTY and out_valid=0 on the next cycle.
- An input offered in the same cycle as flush is discarded, even if in_ready=1.
- A same-cycle output transfer still counts as delivered downstream.

Reset:
- Asserting reset_n low at any time, including mid-transfer, immediately forces state EMPTY, out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_neg=0.
- Deassertion is synchronised externally.
- Payload registers reset to 0; data contents are don't-care only while out_valid=0 after reset.

Decomposition:
- Shared package cpu_pkg:
  - IMM_MODE_ZERO / SIGN / UPPER / BRANCH 2-bit constants.
  - Skid-state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- Sub-module imm_ext_core: purely combinational mode/width extension. It supersedes the old single-mode sign/zero extender and is reusable by the jump-target logic.
- imm_ext_pipe wraps imm_ext_core with the skid buffer and FSM.

Test Plan:
1. Modes, defaults: imm=16'h8001 with modes 00/01/10/11 → out_imm 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004; out_neg 0,1,1,1.
2. Back-pressure: out_ready=0, send tags 1,2,3 → in_ready drops after the 2nd accept, tag 3 is held off. Raise out_ready → outputs tags 1,2,3 in order with no gaps or duplicates.
3. Streaming: out_ready=1, in_valid=1 for 8 cycles → 8 outputs, one per cycle, each 1 cycle after accept; state stays ONE throughout.
4. Flush while FULL, with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and the offered entry never appears.
5. Async reset: assert reset_n low mid-cycle while FULL → outputs are 0 and in_ready=1 without waiting for a clk edge. After release, the first accepted entry emerges correctly.
6. Params IN_W=12, OUT_W=32, SHAMT=1: imm=12'hFFF, mode BRANCH → 32'hFFFFFFFE; mode UPPER → 32'hFFF00000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the immediate-generation stage.
//   IMM_MODE_*   : 2-bit immediate extension mode codes carried on in_mode.
//   skid_state_e : entry-count encoding of the two-entry skid buffer.
package cpu_pkg;

   localparam logic [1:0] IMM_MODE_ZERO   = 2'b00;
   localparam logic [1:0] IMM_MODE_SIGN   = 2'b01;
   localparam logic [1:0] IMM_MODE_UPPER  = 2'b10;
   localparam logic [1:0] IMM_MODE_BRANCH = 2'b11;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_FULL  = 2'd2
   } skid_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Purely combinational immediate widener.
// Ports:
//   in_imm  [IN_W]  raw immediate
//   in_mode [2]     ZERO / SIGN / UPPER / BRANCH
//   ext_imm [OUT_W] widened immediate
// Reusable outside the pipeline stage (e.g. jump-target generation).
module imm_ext_core
   import cpu_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHAMT = 2
) (
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic [OUT_W-1:0] ext_imm
);

   logic [OUT_W-1:0] zext_s;
   logic [OUT_W-1:0] sext_s;

   // Size casts handle IN_W == OUT_W without zero-width replications.
   assign zext_s = OUT_W'(in_imm);
   assign sext_s = OUT_W'($signed(in_imm));

   // Select the extension for the requested mode; shifted-out bits are dropped.
   always_comb begin
      ext_imm = zext_s;
      case (in_mode)
         IMM_MODE_ZERO:   ext_imm = zext_s;
         IMM_MODE_SIGN:   ext_imm = sext_s;
         IMM_MODE_UPPER:  ext_imm = zext_s << (OUT_W - IN_W);
         IMM_MODE_BRANCH: ext_imm = sext_s << SHAMT;
         default:         ext_imm = zext_s;
      endcase
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined ID->EX immediate generation stage.
// Ports:
//   clk, reset_n (async active-low), flush (sync squash)
//   in_valid/in_ready, in_imm, in_mode, in_tag  : upstream entry
//   out_valid/out_ready, out_imm, out_tag, out_neg : head entry
// The immediate is extended on the way in and stored; a two-entry skid
// buffer keeps in_ready a pure flop so it never depends on out_ready.
module imm_ext_pipe
   import cpu_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHAMT = 2,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_neg
);

   logic [OUT_W-1:0] ext_imm_s;
   logic             in_fire_s;
   logic             out_fire_s;

   skid_state_e      state_q,     state_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_imm_q,   out_imm_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;
   logic             out_neg_q,   out_neg_d;
   logic [OUT_W-1:0] skid_imm_q,  skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
   logic             skid_neg_q,  skid_neg_d;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHAMT (SHAMT)
   ) u_core (
      .in_imm  (in_imm),
      .in_mode (in_mode),
      .ext_imm (ext_imm_s)
   );

   // An entry offered during a flush is squashed along with the buffer.
   assign in_fire_s  = in_valid & in_ready_q & ~flush;
   assign out_fire_s = out_valid_q & out_ready;

   // Next-state and payload movement of the skid buffer.
   always_comb begin
      state_d    = state_q;
      out_imm_d  = out_imm_q;
      out_tag_d  = out_tag_q;
      out_neg_d  = out_neg_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_neg_d = skid_neg_q;

      case (state_q)
         SKID_EMPTY: begin
            if (in_fire_s) begin
               out_imm_d = ext_imm_s;
               out_tag_d = in_tag;
               out_neg_d = ext_imm_s[OUT_W-1];
               state_d   = SKID_ONE;
            end else begin
               state_d   = SKID_EMPTY;
            end
         end
         SKID_ONE: begin
            if (in_fire_s && out_fire_s) begin
               // Head leaves and the new entry takes its place.
               out_imm_d = ext_imm_s;
               out_tag_d = in_tag;
               out_neg_d = ext_imm_s[OUT_W-1];
               state_d   = SKID_ONE;
            end else if (in_fire_s) begin
               skid_imm_d = ext_imm_s;
               skid_tag_d = in_tag;
               skid_neg_d = ext_imm_s[OUT_W-1];
               state_d    = SKID_FULL;
            end else if (out_fire_s) begin
               state_d = SKID_EMPTY;
            end else begin
               state_d = SKID_ONE;
            end
         end
         SKID_FULL: begin
            if (out_fire_s) begin
               out_imm_d = skid_imm_q;
               out_tag_d = skid_tag_q;
               out_neg_d = skid_neg_q;
               state_d   = SKID_ONE;
            end else begin
               state_d   = SKID_FULL;
            end
         end
         default: begin
            state_d = SKID_EMPTY;
         end
      endcase

      // A same-cycle output transfer has already been taken downstream.
      if (flush) begin
         state_d = SKID_EMPTY;
      end else begin
         state_d = state_d;
      end

      out_valid_d = (state_d != SKID_EMPTY);
      in_ready_d  = (state_d != SKID_FULL);
   end

   // State, handshake and payload registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SKID_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_imm_q   <= '0;
         out_tag_q   <= '0;
         out_neg_q   <= 1'b0;
         skid_imm_q  <= '0;
         skid_tag_q  <= '0;
         skid_neg_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_imm_q   <= out_imm_d;
         out_tag_q   <= out_tag_d;
         out_neg_q   <= out_neg_d;
         skid_imm_q  <= skid_imm_d;
         skid_tag_q  <= skid_tag_d;
         skid_neg_q  <= skid_neg_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_imm   = out_imm_q;
   assign out_tag   = out_tag_q;
   assign out_neg   = out_neg_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed scenarios plus random
// traffic checked against a queue-based FIFO reference model.
module tb_imm_ext_pipe;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [31:0] in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [31:0] out_tag;
   logic        out_neg;

   // Second instance with non-default parameters.
   logic        b_flush;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [11:0] b_in_imm;
   logic [1:0]  b_in_mode;
   logic [31:0] b_in_tag;
   logic        b_out_valid;
   logic        b_out_ready;
   logic [31:0] b_out_imm;
   logic [31:0] b_out_tag;
   logic        b_out_neg;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] imm;
      logic [31:0] tag;
      logic        neg;
   } ent_t;

   ent_t exp_q[$];

   imm_ext_pipe u_dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
      .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_tag(out_tag), .out_neg(out_neg)
   );

   imm_ext_pipe #(.IN_W(12), .OUT_W(32), .SHAMT(1), .TAG_W(32)) u_dut12 (
      .clk(clk), .reset_n(reset_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
      .in_mode(b_in_mode), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
      .out_tag(b_out_tag), .out_neg(b_out_neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference extension written as plain integer arithmetic.
   function automatic logic [31:0] ref_ext(input int inw, input int shamt,
                                           input logic [31:0] imm, input logic [1:0] mode);
      longint u, s, r;
      u = longint'(imm) & ((longint'(1) << inw) - 1);
      s = (((u >> (inw - 1)) & 1) != 0) ? u - (longint'(1) << inw) : u;
      case (mode)
         2'd0:    r = u;
         2'd1:    r = s;
         2'd2:    r = u * (longint'(1) << (32 - inw));
         default: r = s * (longint'(1) << shamt);
      endcase
      return r[31:0];
   endfunction

   // Compare DUT with the model, then advance one clock and update the model.
   task automatic step();
      bit   inf, outf;
      ent_t e;
      check_eq("in_ready",  {63'd0, in_ready},  {63'd0, exp_q.size() < 2});
      check_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
         check_eq("out_imm", {32'd0, out_imm}, {32'd0, exp_q[0].imm});
         check_eq("out_tag", {32'd0, out_tag}, {32'd0, exp_q[0].tag});
         check_eq("out_neg", {63'd0, out_neg}, {63'd0, exp_q[0].neg});
      end
      inf  = in_valid && (exp_q.size() < 2) && !flush;
      outf = (exp_q.size() > 0) && out_ready;
      e.imm = ref_ext(16, 2, {16'd0, in_imm}, in_mode);
      e.tag = in_tag;
      e.neg = e.imm[31];
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
      end else begin
         if (outf) void'(exp_q.pop_front());
         if (inf) exp_q.push_back(e);
      end
      #1;
   endtask

   task automatic offer(input logic [15:0] imm, input logic [1:0] mode, input logic [31:0] tag);
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
   endtask

   logic [31:0] mode_exp [4];
   logic        neg_exp  [4];

   initial begin
      mode_exp[0] = 32'h00008001; neg_exp[0] = 1'b0;
      mode_exp[1] = 32'hFFFF8001; neg_exp[1] = 1'b1;
      mode_exp[2] = 32'h80010000; neg_exp[2] = 1'b1;
      mode_exp[3] = 32'hFFFE0004; neg_exp[3] = 1'b1;

      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = 16'd0;
      in_mode = 2'd0; in_tag = 32'd0; out_ready = 1'b0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_imm = 12'd0; b_in_mode = 2'd0;
      b_in_tag = 32'd0; b_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_in_ready",  {63'd0, in_ready},  64'd1);
      check_eq("rst_out_imm",   {32'd0, out_imm},   64'd0);
      check_eq("rst_out_tag",   {32'd0, out_tag},   64'd0);
      reset_n = 1'b1;

      // Test 1: the four modes on 16'h8001.
      out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         offer(16'h8001, m[1:0], 32'h100 + m);
         step();
         in_valid = 1'b0;
         check_eq("t1_mode_imm", {32'd0, out_imm}, {32'd0, mode_exp[m]});
         check_eq("t1_mode_neg", {63'd0, out_neg}, {63'd0, neg_exp[m]});
         step();
      end

      // Test 2: back-pressure holds off the third entry, order preserved.
      out_ready = 1'b0;
      offer(16'h0011, 2'd1, 32'd1); step();
      offer(16'h0022, 2'd1, 32'd2); step();
      offer(16'h0033, 2'd1, 32'd3); step();
      check_eq("t2_in_ready_full", {63'd0, in_ready}, 64'd0);
      check_eq("t2_head_tag",      {32'd0, out_tag},  64'd1);
      step();
      out_ready = 1'b1;
      step();
      check_eq("t2_second_tag", {32'd0, out_tag}, 64'd2);
      step();
      in_valid = 1'b0;
      check_eq("t2_third_tag", {32'd0, out_tag}, 64'd3);
      step();
      step();

      // Test 3: streaming, one entry per cycle.
      for (int i = 0; i < 8; i++) begin
         offer(16'(i * 16'h1111), i[1:0], 32'h200 + i);
         step();
         check_eq("t3_stream_tag", {32'd0, out_tag}, {32'd0, 32'h200 + i});
      end
      in_valid = 1'b0;
      step();

      // Test 4: flush while full, with a same-cycle offer.
      out_ready = 1'b0;
      offer(16'h0A0A, 2'd0, 32'h300); step();
      offer(16'h0B0B, 2'd0, 32'h301); step();
      flush = 1'b1;
      offer(16'hDEAD, 2'd0, 32'hDEAD);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check_eq("t4_flush_valid", {63'd0, out_valid}, 64'd0);
      check_eq("t4_flush_ready", {63'd0, in_ready},  64'd1);
      out_ready = 1'b1;
      step();
      step();

      // Test 5: asynchronous reset mid-cycle while full.
      out_ready = 1'b0;
      offer(16'hF00F, 2'd1, 32'h400); step();
      offer(16'h1234, 2'd2, 32'h401); step();
      in_valid = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("t5_rst_valid", {63'd0, out_valid}, 64'd0);
      check_eq("t5_rst_ready", {63'd0, in_ready},  64'd1);
      check_eq("t5_rst_imm",   {32'd0, out_imm},   64'd0);
      check_eq("t5_rst_tag",   {32'd0, out_tag},   64'd0);
      check_eq("t5_rst_neg",   {63'd0, out_neg},   64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      offer(16'h7FFF, 2'd3, 32'h402); step();
      in_valid = 1'b0;
      check_eq("t5_after_imm", {32'd0, out_imm}, 64'h0001FFFC);
      step();

      // Test 6: IN_W=12, SHAMT=1 instance.
      b_in_valid = 1'b1; b_in_imm = 12'hFFF; b_in_mode = 2'd3; b_in_tag = 32'h500;
      step();
      b_in_mode = 2'd2; b_in_tag = 32'h501;
      check_eq("t6_branch_valid", {63'd0, b_out_valid}, 64'd1);
      check_eq("t6_branch_imm",   {32'd0, b_out_imm},   {32'd0, ref_ext(12, 1, 32'hFFF, 2'd3)});
      check_eq("t6_branch_const", {32'd0, b_out_imm},   64'hFFFFFFFE);
      step();
      b_in_valid = 1'b0;
      check_eq("t6_upper_const",  {32'd0, b_out_imm},   64'hFFF00000);
      check_eq("t6_upper_tag",    {32'd0, b_out_tag},   64'h501);
      check_eq("t6_upper_neg",    {63'd0, b_out_neg},   64'd1);
      step();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_imm    = 16'($urandom);
         in_mode   = 2'($urandom);
         in_tag    = $urandom;
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
